// File: rtl/jtdsp16_loader_pkg.sv
// jtdsp16_loader_pkg
//   Shared definitions for the DSP16 boot loader.
//   - FSM state encoding (exposed on the loader's state_dbg port)
//   - Default internal ROM address width (8 KB program ROM)
//   - Width of the shared timeout / reset-hold down-counter
//   - Helper that converts a cycle count into a down-counter preset
//   Optional feature macro used by the loader: JTDSP16_LOADER_CHK_EN.
package jtdsp16_loader_pkg;

  localparam int JTDSP16_ROM_AW = 13;
  localparam int TMR_W          = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  // The counter is loaded with N-1 and the zero flag is consumed while the
  // FSM is still in the state, so the state lasts exactly N cycles.
  function automatic logic [TMR_W-1:0] tmr_preset(input int cycles);
    return (cycles > 0) ? TMR_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/jtdsp16_loader_if.sv
// jtdsp16_loader_if
//   Bus bundle between the loader, the external source memory and the
//   internal program ROM.
//   Source read port:
//     src_addr  loader -> mem   external byte address
//     src_req   loader -> mem   read request
//     src_ok    mem -> loader   read done, src_data valid in the same cycle
//     src_data  mem -> loader   read data
//   ROM programming port:
//     prog_addr / prog_data / prog_we   loader -> ROM
//
//   Handshake: src_req is raised by the loader and held, with src_addr stable,
//   until the memory answers with src_ok. The byte is taken in the cycle where
//   src_req and src_ok are both high; src_req drops the following cycle. A
//   src_ok seen while src_req is low is ignored. prog_we is a single-cycle
//   strobe and prog_addr/prog_data are stable while it is high.
//   Modports: master = loader side, slave = memory / ROM side.
interface jtdsp16_loader_if
  import jtdsp16_loader_pkg::*;
#(
  parameter int AW  = JTDSP16_ROM_AW,
  parameter int SAW = 22
);

  logic [SAW-1:0] src_addr;
  logic           src_req;
  logic           src_ok;
  logic [7:0]     src_data;
  logic [AW-1:0]  prog_addr;
  logic [7:0]     prog_data;
  logic           prog_we;

  modport master (
    output src_addr, src_req, prog_addr, prog_data, prog_we,
    input  src_ok, src_data
  );

  modport slave (
    input  src_addr, src_req, prog_addr, prog_data, prog_we,
    output src_ok, src_data
  );

endinterface

// File: rtl/jtdsp16_loader_tmr.sv
// jtdsp16_loader_tmr
//   Loadable down-counter shared by the source-timeout wait and the
//   core-reset hold. It saturates at zero.
//   Ports:
//     clk       in   system clock
//     rst_n     in   synchronous active-low reset
//     load      in   load load_val (has priority over en)
//     load_val  in   preset value
//     en        in   count down by one while non-zero
//     zero      out  counter is zero
module jtdsp16_loader_tmr
  import jtdsp16_loader_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/jtdsp16_loader.sv
// jtdsp16_loader
//   Boot sequencer for the DSP16 core. Holds the core in reset, copies the
//   program image byte by byte from external memory into the internal ROM,
//   waits RST_HOLD cycles and then releases the core.
//   Ports:
//     clk        in   system clock
//     rst_n      in   synchronous active-low reset
//     start      in   load request pulse (a load also starts on leaving reset)
//     base       in   external byte address of image byte 0
//     bus        master side of jtdsp16_loader_if (src_* read port, prog_* ROM port)
//     dsp_rst    out  core reset, active high
//     busy       out  load in progress (FETCH/WRITE/HOLD)
//     done       out  image loaded, core running
//     fault      out  source timeout, core held in reset
//     chk_sum    out  16-bit wrapping sum of the loaded bytes
//     state_dbg  out  current FSM state
//   Configuration macro: JTDSP16_LOADER_CHK_EN enables the checksum adder;
//   without it chk_sum is constant zero.
//   All outputs are registered.
module jtdsp16_loader
  import jtdsp16_loader_pkg::*;
#(
  parameter int AW       = JTDSP16_ROM_AW,
  parameter int SAW      = 22,
  parameter int TIMEOUT  = 1023,
  parameter int RST_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SAW-1:0]          base,
  jtdsp16_loader_if.master        bus,
  output logic                    dsp_rst,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic [15:0]             chk_sum,
  output state_t                  state_dbg
);

  localparam logic [AW-1:0]    ADDR_LAST    = '1;
  localparam logic [TMR_W-1:0] FETCH_PRESET = tmr_preset(TIMEOUT);
  localparam logic [TMR_W-1:0] HOLD_PRESET  = tmr_preset(RST_HOLD);

  state_t state, state_d;

  // Registered outputs and their next values
  logic           src_req_q,   src_req_d;
  logic           prog_we_q,   prog_we_d;
  logic           dsp_rst_q,   dsp_rst_d;
  logic           busy_q,      busy_d;
  logic           done_q,      done_d;
  logic           fault_q,     fault_d;
  logic [SAW-1:0] src_addr_q,  src_addr_d;
  logic [AW-1:0]  prog_addr_q, prog_addr_d;
  logic [7:0]     prog_data_q, prog_data_d;
  logic [SAW-1:0] base_q,      base_d;

  logic [AW-1:0]    prog_addr_inc;
  logic             last_byte;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  assign prog_addr_inc = prog_addr_q + AW'(1);
  assign last_byte     = (prog_addr_q == ADDR_LAST);

  // ---------------------------------------------------------------------------
  // Shared timer: reloaded on every entry into FETCH (timeout) and into HOLD
  // (core reset hold); counts only while the FSM sits in one of those states.
  // ---------------------------------------------------------------------------
  assign tmr_load = (state_d != state) && ((state_d == FETCH) || (state_d == HOLD));
  assign tmr_val  = (state_d == HOLD) ? HOLD_PRESET : FETCH_PRESET;
  assign tmr_en   = (state == FETCH) || (state == HOLD);

  jtdsp16_loader_tmr #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // ---------------------------------------------------------------------------
  // State register (outputs are registered alongside the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_req_q   <= 1'b0;
      prog_we_q   <= 1'b0;
      dsp_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      src_addr_q  <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      base_q      <= '0;
    end else begin
      state       <= state_d;
      src_req_q   <= src_req_d;
      prog_we_q   <= prog_we_d;
      dsp_rst_q   <= dsp_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      src_addr_q  <= src_addr_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      base_q      <= base_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. IDLE is only ever occupied for one cycle: it is entered
  // from reset or from a start in DONE/FAIL, and always proceeds to a load.
  // start in FETCH/WRITE/HOLD is not looked at, so a start coinciding with
  // src_ok cannot disturb the byte being accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = FETCH;
      FETCH: begin
        if (bus.src_ok) begin
          state_d = WRITE;
        end else if (tmr_zero) begin
          state_d = FAIL;
        end
      end
      WRITE:   state_d = last_byte ? HOLD : FETCH;
      HOLD:    if (tmr_zero) state_d = DONE;
      DONE:    if (start) state_d = IDLE;
      FAIL:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Control strobes are
  // decoded from the next state so they line up with the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_req_d   = (state_d == FETCH);
    prog_we_d   = (state_d == WRITE);
    dsp_rst_d   = (state_d != DONE);
    busy_d      = (state_d == FETCH) || (state_d == WRITE) || (state_d == HOLD);
    done_d      = (state_d == DONE);
    fault_d     = (state_d == FAIL);
    src_addr_d  = src_addr_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    base_d      = base_q;

    // Load start: capture base and restart from ROM byte 0.
    if (state == IDLE) begin
      base_d      = base;
      prog_addr_d = '0;
      src_addr_d  = base;
    end

    if ((state == FETCH) && bus.src_ok) begin
      prog_data_d = bus.src_data;
    end

    // The last ROM byte leaves prog_addr in place so it never wraps to 0.
    if ((state == WRITE) && !last_byte) begin
      prog_addr_d = prog_addr_inc;
      src_addr_d  = base_q + SAW'(prog_addr_inc);
    end
  end

  // ---------------------------------------------------------------------------
  // Optional checksum of the bytes written in the current load
  // ---------------------------------------------------------------------------
`ifdef JTDSP16_LOADER_CHK_EN
  logic [15:0] chk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (state == IDLE) begin
      chk_q <= '0;
    end else if ((state == FETCH) && bus.src_ok) begin
      chk_q <= chk_q + 16'(bus.src_data);
    end
  end

  assign chk_sum = chk_q;
`else
  assign chk_sum = '0;
`endif

  assign bus.src_req   = src_req_q;
  assign bus.src_addr  = src_addr_q;
  assign bus.prog_we   = prog_we_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign dsp_rst       = dsp_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_jtdsp16_loader.sv
`timescale 1ns/1ps
module tb_jtdsp16_loader;
  import jtdsp16_loader_pkg::*;

  localparam int AW       = 4;
  localparam int SAW      = 22;
  localparam int TIMEOUT  = 8;
  localparam int RST_HOLD = 5;
  localparam int NB       = 1 << AW;
  localparam int BIG_AW   = 13;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           start;
  logic [SAW-1:0] base;
  logic           dsp_rst, busy, done, fault;
  logic [15:0]    chk_sum;
  state_t         state_dbg;

  jtdsp16_loader_if #(.AW(AW), .SAW(SAW)) bus ();

  jtdsp16_loader #(.AW(AW), .SAW(SAW), .TIMEOUT(TIMEOUT), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .bus(bus),
    .dsp_rst(dsp_rst), .busy(busy), .done(done), .fault(fault),
    .chk_sum(chk_sum), .state_dbg(state_dbg)
  );

  // Full-size instance for the 8 KB checksum case, fed all-0xFF bytes
  logic           big_rst_n;
  logic           big_start;
  logic [SAW-1:0] big_base;
  logic           big_dsp_rst, big_busy, big_done, big_fault;
  logic [15:0]    big_chk;
  state_t         big_state;

  jtdsp16_loader_if #(.AW(BIG_AW), .SAW(SAW)) big_bus ();

  jtdsp16_loader #(.AW(BIG_AW), .SAW(SAW), .TIMEOUT(1023), .RST_HOLD(16)) dut_big (
    .clk(clk), .rst_n(big_rst_n), .start(big_start), .base(big_base), .bus(big_bus),
    .dsp_rst(big_dsp_rst), .busy(big_busy), .done(big_done), .fault(big_fault),
    .chk_sum(big_chk), .state_dbg(big_state)
  );

  assign big_bus.src_ok   = big_bus.src_req;
  assign big_bus.src_data = 8'hFF;

  int                big_wr_n  = 0;
  int                big_bad_d = 0;
  logic [BIG_AW-1:0] big_last  = '0;

  initial begin
    big_start = 1'b0;
    big_base  = '0;
    big_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    big_rst_n = 1'b1;
  end

  always @(negedge clk) begin
    if (big_bus.prog_we === 1'b1) begin
      big_wr_n++;
      big_last = big_bus.prog_addr;
      if (big_bus.prog_data !== 8'hFF) big_bad_d++;
    end
  end

  // ------------------------------------------------------------ memory model
  logic [7:0] key       = 8'h00;
  bit         ok_en     = 1'b1;
  bit         noise_en  = 1'b0;
  int         delay_min = 0;
  int         delay_max = 0;
  int         cur_delay = 0;
  int         wait_cnt  = 0;

  function automatic logic [7:0] mem_byte(input logic [SAW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ key;
  endfunction

  // Source memory responder: answers a request after cur_delay idle cycles,
  // and optionally throws junk src_ok pulses while no request is pending.
  initial begin
    bus.src_ok   = 1'b0;
    bus.src_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.src_req === 1'b1) begin
        if (ok_en && (wait_cnt >= cur_delay)) begin
          bus.src_ok   = 1'b1;
          bus.src_data = mem_byte(bus.src_addr);
          wait_cnt     = 0;
          cur_delay    = $urandom_range(delay_max, delay_min);
        end else begin
          bus.src_ok   = 1'b0;
          bus.src_data = 8'($urandom);
          if (ok_en) wait_cnt++;
        end
      end else begin
        wait_cnt     = 0;
        bus.src_ok   = noise_en ? 1'($urandom_range(1, 0)) : 1'b0;
        bus.src_data = 8'($urandom);
      end
    end
  end

  // -------------------------------------------------------------- scoreboard
  int              n_chk = 0;
  int              n_bad = 0;
  int              cyc   = 0;
  logic [AW+7:0]   wr_q[$];
  logic [AW+7:0]   exp_q[$];
  int              t_busy, t_done, t_lastwe, n_req;
  bit              timed_out;

  // Expected ROM image: byte i of the load comes from source address base+i.
  task automatic build_exp(input logic [SAW-1:0] b);
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back({AW'(i), mem_byte(b + SAW'(i))});
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (wr_q[i] !== exp_q[i]) return i;
    end
    if (wr_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [15:0] exp_sum();
    logic [15:0] s;
    s = '0;
    foreach (exp_q[i]) s = s + 16'(exp_q[i][7:0]);
    return s;
  endfunction

  // ------------------------------------------------------------ driver tasks
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.prog_we === 1'b1) wr_q.push_back({bus.prog_addr, bus.prog_data});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_end(input int budget);
    t_busy    = -1;
    t_done    = -1;
    t_lastwe  = -1;
    n_req     = 0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((busy === 1'b1) && (t_busy < 0)) t_busy = cyc;
      if (bus.src_req === 1'b1) n_req++;
      if (bus.prog_we === 1'b1) t_lastwe = cyc;
      if ((done === 1'b1) || (fault === 1'b1)) begin
        t_done    = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    base  = '0;
    repeat (3) tick();
    n_chk++; if (bus.src_req !== 1'b0)   begin n_bad++; $display("FAIL reset_src_req: got %b want 0", bus.src_req); end
    n_chk++; if (bus.prog_we !== 1'b0)   begin n_bad++; $display("FAIL reset_prog_we: got %b want 0", bus.prog_we); end
    n_chk++; if (bus.prog_addr !== '0)   begin n_bad++; $display("FAIL reset_prog_addr: got %0h want 0", bus.prog_addr); end
    n_chk++; if (bus.prog_data !== '0)   begin n_bad++; $display("FAIL reset_prog_data: got %0h want 0", bus.prog_data); end
    n_chk++; if (bus.src_addr !== '0)    begin n_bad++; $display("FAIL reset_src_addr: got %0h want 0", bus.src_addr); end
    n_chk++; if (dsp_rst !== 1'b1)       begin n_bad++; $display("FAIL reset_dsp_rst: got %b want 1", dsp_rst); end
    n_chk++; if (busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0)          begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (fault !== 1'b0)         begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_chk++; if (chk_sum !== 16'h0)      begin n_bad++; $display("FAIL reset_chk_sum: got %0h want 0", chk_sum); end
  endtask

  task automatic test_basic();
    int          d;
    logic [15:0] want_chk;
    key       = 8'h00;
    base      = '0;
    delay_min = 0; delay_max = 0; cur_delay = 0;
    noise_en  = 1'b0;
    build_exp('0);
    wr_q.delete();
    rst_n = 1'b1;
    run_to_end(200);
    n_chk++; if (timed_out || (done !== 1'b1)) begin n_bad++; $display("FAIL basic_done: got done=%b timeout=%0d want done=1", done, timed_out); end
    n_chk++; if ((t_done - t_busy) != (2 * NB + RST_HOLD)) begin n_bad++; $display("FAIL basic_total_cycles: got %0d want %0d", t_done - t_busy, 2 * NB + RST_HOLD); end
    n_chk++; if ((t_done - t_lastwe) != (RST_HOLD + 1)) begin n_bad++; $display("FAIL basic_rst_release: got %0d want %0d", t_done - t_lastwe, RST_HOLD + 1); end
    n_chk++; if ((dsp_rst !== 1'b0) || (busy !== 1'b0)) begin n_bad++; $display("FAIL basic_core_run: got dsp_rst=%b busy=%b want 0 0", dsp_rst, busy); end
    n_chk++; if (n_req != NB) begin n_bad++; $display("FAIL basic_req_cycles: got %0d want %0d", n_req, NB); end
    d = first_diff();
    n_chk++; if (d >= 0) begin n_bad++; $display("FAIL basic_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size(), exp_q.size()); end
`ifdef JTDSP16_LOADER_CHK_EN
    want_chk = exp_sum();
`else
    want_chk = 16'h0;
`endif
    n_chk++; if (chk_sum !== want_chk) begin n_bad++; $display("FAIL basic_chk_sum: got %0h want %0h", chk_sum, want_chk); end
  endtask

  task automatic test_slow();
    int d;
    key       = 8'($urandom);
    base      = SAW'($urandom);
    delay_min = 3; delay_max = 3; cur_delay = 3;
    build_exp(base);
    wr_q.delete();
    pulse_start();
    run_to_end(400);
    n_chk++; if (timed_out || (done !== 1'b1)) begin n_bad++; $display("FAIL slow_done: got done=%b timeout=%0d want done=1", done, timed_out); end
    n_chk++; if (n_req != NB * 4) begin n_bad++; $display("FAIL slow_req_held: got %0d want %0d", n_req, NB * 4); end
    n_chk++; if ((t_done - t_busy) != (5 * NB + RST_HOLD)) begin n_bad++; $display("FAIL slow_total_cycles: got %0d want %0d", t_done - t_busy, 5 * NB + RST_HOLD); end
    d = first_diff();
    n_chk++; if (d >= 0) begin n_bad++; $display("FAIL slow_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    int d;
    int n_starts;
    bit reached;
    key       = 8'($urandom);
    base      = {SAW{1'b1}} - SAW'(5);
    delay_min = 0; delay_max = 3; cur_delay = 1;
    noise_en  = 1'b1;
    n_starts  = 0;
    reached   = 1'b0;
    build_exp(base);
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      start = (busy === 1'b1) && ($urandom_range(3, 0) == 0);
      if (start) n_starts++;
      tick();
      if (done === 1'b1) begin
        reached = 1'b1;
        break;
      end
    end
    start    = 1'b0;
    noise_en = 1'b0;
    n_chk++; if (!reached || (fault !== 1'b0)) begin n_bad++; $display("FAIL random_done: got done=%b fault=%b want 1 0", done, fault); end
    d = first_diff();
    n_chk++; if (d >= 0) begin n_bad++; $display("FAIL random_writes: diff at %0d, got %0d writes want %0d (starts=%0d)", d, wr_q.size(), exp_q.size(), n_starts); end
  endtask

  task automatic test_timeout();
    int d;
    ok_en = 1'b0;
    wr_q.delete();
    pulse_start();
    run_to_end(100);
    n_chk++; if (timed_out || (fault !== 1'b1)) begin n_bad++; $display("FAIL timeout_fault: got fault=%b want 1", fault); end
    n_chk++; if (n_req != TIMEOUT) begin n_bad++; $display("FAIL timeout_fetch_cycles: got %0d want %0d", n_req, TIMEOUT); end
    n_chk++; if ((bus.src_req !== 1'b0) || (dsp_rst !== 1'b1) || (busy !== 1'b0) || (done !== 1'b0)) begin
      n_bad++; $display("FAIL timeout_outputs: got req=%b rst=%b busy=%b done=%b want 0 1 0 0", bus.src_req, dsp_rst, busy, done);
    end
    n_chk++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL timeout_no_write: got %0d writes want 0", wr_q.size()); end
    ok_en     = 1'b1;
    delay_min = 0; delay_max = 2; cur_delay = 0;
    build_exp(base);
    pulse_start();
    n_chk++; if (fault !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got fault=%b want 0", fault); end
    run_to_end(300);
    n_chk++; if (timed_out || (done !== 1'b1)) begin n_bad++; $display("FAIL retry_done: got done=%b want 1", done); end
    d = first_diff();
    n_chk++; if (d >= 0) begin n_bad++; $display("FAIL retry_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d;
    bit found;
    key       = 8'($urandom);
    base      = SAW'($urandom);
    delay_min = 0; delay_max = 0; cur_delay = 0;
    found     = 1'b0;
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      tick();
      if ((bus.prog_we === 1'b1) && (bus.prog_addr === AW'(5))) begin
        found = 1'b1;
        break;
      end
    end
    n_chk++; if (!found) begin n_bad++; $display("FAIL midrst_reach_byte5: got %0d writes want byte 5", wr_q.size()); end
    rst_n = 1'b0;
    tick();
    n_chk++; if ((bus.prog_we !== 1'b0) || (dsp_rst !== 1'b1) || (bus.prog_addr !== '0) || (busy !== 1'b0)) begin
      n_bad++; $display("FAIL midrst_outputs: got we=%b rst=%b addr=%0h busy=%b want 0 1 0 0", bus.prog_we, dsp_rst, bus.prog_addr, busy);
    end
    tick();
    n_chk++; if (wr_q.size() != 6) begin n_bad++; $display("FAIL midrst_writes_stop: got %0d writes want 6", wr_q.size()); end
    build_exp(base);
    wr_q.delete();
    rst_n = 1'b1;
    run_to_end(200);
    n_chk++; if (timed_out || (done !== 1'b1)) begin n_bad++; $display("FAIL midrst_reload_done: got done=%b want 1", done); end
    n_chk++; if ((t_done - t_busy) != (2 * NB + RST_HOLD)) begin n_bad++; $display("FAIL midrst_reload_cycles: got %0d want %0d", t_done - t_busy, 2 * NB + RST_HOLD); end
    d = first_diff();
    n_chk++; if (d >= 0) begin n_bad++; $display("FAIL midrst_reload_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_start_ctrl();
    int d;
    bit found;
    key   = 8'($urandom);
    base  = SAW'($urandom);
    found = 1'b0;
    build_exp(base);
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.prog_we === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_end(200);
    n_chk++; if (!found || timed_out || (done !== 1'b1)) begin n_bad++; $display("FAIL start_in_write_done: got done=%b want 1", done); end
    d = first_diff();
    n_chk++; if (d >= 0) begin n_bad++; $display("FAIL start_in_write_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size(), exp_q.size()); end
    base = SAW'(22'h001000);
    build_exp(base);
    wr_q.delete();
    pulse_start();
    n_chk++; if ((dsp_rst !== 1'b1) || (done !== 1'b0)) begin n_bad++; $display("FAIL start_in_done_rst: got rst=%b done=%b want 1 0", dsp_rst, done); end
    tick();
    n_chk++; if ((bus.src_req !== 1'b1) || (bus.src_addr !== SAW'(22'h001000))) begin
      n_bad++; $display("FAIL start_in_done_addr: got req=%b addr=%0h want 1 1000", bus.src_req, bus.src_addr);
    end
    run_to_end(200);
    n_chk++; if (timed_out || (done !== 1'b1)) begin n_bad++; $display("FAIL reload_done: got done=%b want 1", done); end
    d = first_diff();
    n_chk++; if (d >= 0) begin n_bad++; $display("FAIL reload_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_chk();
    logic [15:0] want;
    bit          reached;
    reached = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (big_done === 1'b1) begin
        reached = 1'b1;
        break;
      end
    end
`ifdef JTDSP16_LOADER_CHK_EN
    want = 16'((1 << BIG_AW) * 255);
`else
    want = 16'h0;
`endif
    n_chk++; if (!reached || (big_dsp_rst !== 1'b0)) begin n_bad++; $display("FAIL big_done: got done=%b rst=%b want 1 0", big_done, big_dsp_rst); end
    n_chk++; if (big_wr_n != (1 << BIG_AW)) begin n_bad++; $display("FAIL big_write_count: got %0d want %0d", big_wr_n, 1 << BIG_AW); end
    n_chk++; if ((big_last !== {BIG_AW{1'b1}}) || (big_bad_d != 0)) begin
      n_bad++; $display("FAIL big_last_write: got addr=%0h bad_data=%0d want %0h 0", big_last, big_bad_d, {BIG_AW{1'b1}});
    end
    n_chk++; if (big_chk !== want) begin n_bad++; $display("FAIL big_chk_sum: got %0h want %0h", big_chk, want); end
  endtask

  // -------------------------------------------------------------- main flow
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base  = '0;
    test_reset();
    test_basic();
    test_slow();
    test_random();
    test_timeout();
    test_reset_mid();
    test_start_ctrl();
    test_chk();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
